// File: rtl/ttl_dec_pkg.sv
// Shared types and helpers for the 74148 code decoder.
// State encoding, idle/reset constants and 1-of-8 expansion.
package ttl_dec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [7:0] NOUT_IDLE = 8'hFF;
  localparam logic       SYNC_RST  = 1'b1;

  // Active-low 1-of-8: only bit [code] is low.
  function automatic logic [7:0] onehot_n(
    input logic [2:0] code
  );
    logic [7:0] v;
    v       = NOUT_IDLE;
    v[code] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser, parameterised width.
// Resets to all ones so active-low inputs read as inactive.
module sync2
  import ttl_dec_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Double-register the asynchronous bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {W{SYNC_RST}};
      q    <= {W{SYNC_RST}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ttl74148_code_decoder.sv
// Receive side of a 74148 priority-code link.
// Sync, debounce, 1-of-8 expand, hold and handshake.
module ttl74148_code_decoder
  import ttl_dec_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int HOLD_CYC   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nE,
  input  logic [2:0] nY,
  input  logic       nGS,
  input  logic       nEO,
  output logic [7:0] nOUT,
  output logic       valid,
  input  logic       ack,
  output logic [2:0] code_o,
  output logic       err
);

  localparam int MAXC =
    (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SETTLE_LAST =
    CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_CYC - 1);

  logic [4:0]    syncIn;
  logic [4:0]    syncOut;
  logic [2:0]    nYS;
  logic          nGsS;
  logic          nEoS;
  logic [2:0]    codeS;
  logic          illegal;
  logic          gsActive;
  logic          hsDone;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [2:0]    cap;

  assign syncIn = {nY, nGS, nEO};

  sync2 #(
    .W (5)
  ) uSync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (syncIn),
    .q     (syncOut)
  );

  assign nYS   = syncOut[4:2];
  assign nGsS  = syncOut[1];
  assign nEoS  = syncOut[0];
  assign codeS = ~nYS;

  // GS and EO both low cannot come from a sane encoder;
  // such a cycle counts as "no group active".
  assign illegal  = !nGsS && !nEoS;
  assign gsActive = !nGsS && !illegal;

  // Handshake is finished once valid dropped or acks now.
  assign hsDone = !valid || ack;

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end
  end

  // Debounce FSM with hold counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      cap    <= '0;
      nOUT   <= NOUT_IDLE;
      valid  <= 1'b0;
      code_o <= '0;
    end else if (nE) begin
      state <= IDLE;
      cnt   <= '0;
      nOUT  <= NOUT_IDLE;
      valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          nOUT  <= NOUT_IDLE;
          valid <= 1'b0;
          if (gsActive) begin
            cap   <= codeS;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (!gsActive || codeS != cap) begin
            state <= IDLE;
          end else if (cnt == SETTLE_LAST) begin
            state  <= DRIVE;
            nOUT   <= onehot_n(cap);
            code_o <= cap;
            valid  <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt != HOLD_LAST) begin
            cnt <= cnt + 1'b1;
          end
          if (valid && ack) begin
            valid <= 1'b0;
          end
          if (hsDone && cnt == HOLD_LAST) begin
            state <= RELEASE;
            nOUT  <= NOUT_IDLE;
          end
        end
        RELEASE: begin
          nOUT  <= NOUT_IDLE;
          valid <= 1'b0;
          if (!gsActive) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttl74148_code_decoder.sv
// Bench for ttl74148_code_decoder: cycle-stamp model
// compared every cycle plus directed literal checks.
module tb_ttl74148_code_decoder;

  localparam int SETTLE_CYC = 4;
  localparam int HOLD_CYC   = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       nE    = 1'b0;
  logic [2:0] nY    = 3'b111;
  logic       nGS   = 1'b1;
  logic       nEO   = 1'b1;
  logic       ack   = 1'b0;
  logic [7:0] nOUT;
  logic       valid;
  logic [2:0] code_o;
  logic       err;

  int nRun  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  ttl74148_code_decoder #(
    .SETTLE_CYC (SETTLE_CYC),
    .HOLD_CYC   (HOLD_CYC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .nE     (nE),
    .nY     (nY),
    .nGS    (nGS),
    .nEO    (nEO),
    .nOUT   (nOUT),
    .valid  (valid),
    .ack    (ack),
    .code_o (code_o),
    .err    (err)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Model: inputs seen two edges late; decode timing from
  // cycle stamps of capture and drive start.
  logic [4:0] p1, p2;
  int         cyc, mode, tCap, tDrive;
  bit         acked;
  logic       mGs, mIll;
  logic [2:0] mCodeS, mCap, mCode;
  logic [7:0] mOut;
  logic       mValid, mErr;
  bit         mDone;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 = '1; p2 = '1; cyc = 0; mode = 0;
      mCap = 0; mOut = 8'hFF; mValid = 0;
      mCode = 0; mErr = 0; acked = 0;
      tCap = 0; tDrive = 0;
    end else begin
      cyc++;
      mCodeS = ~p2[4:2];
      mIll   = !p2[1] && !p2[0];
      mGs    = !p2[1] && !mIll;
      if (mIll) mErr = 1'b1;
      if (nE) begin
        mode = 0; mOut = 8'hFF; mValid = 0;
      end else if (mode == 0) begin
        if (mGs) begin
          mCap = mCodeS; tCap = cyc; mode = 1;
        end
      end else if (mode == 1) begin
        if (!mGs || mCodeS != mCap) begin
          mode = 0;
        end else if (cyc - tCap == SETTLE_CYC) begin
          mode = 2; tDrive = cyc; acked = 0;
          mOut = ~(8'd1 << mCap);
          mCode = mCap; mValid = 1;
        end
      end else if (mode == 2) begin
        mDone = acked || (mValid && ack);
        if (mValid && ack) begin
          mValid = 0; acked = 1;
        end
        if (mDone && cyc - tDrive >= HOLD_CYC) begin
          mode = 3; mOut = 8'hFF;
        end
      end else begin
        if (!mGs) mode = 0;
      end
      p2 = p1;
      p1 = {nY, nGS, nEO};
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("cyc_nOUT",  {24'd0, nOUT},   {24'd0, mOut});
      chk("cyc_valid", {31'd0, valid},  {31'd0, mValid});
      chk("cyc_code",  {29'd0, code_o}, {29'd0, mCode});
      chk("cyc_err",   {31'd0, err},    {31'd0, mErr});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [2:0] c;
    logic [7:0] e;
    tick(2);
    chk("rst_nOUT",  {24'd0, nOUT},   32'hFF);
    chk("rst_valid", {31'd0, valid},  32'd0);
    chk("rst_code",  {29'd0, code_o}, 32'd0);
    chk("rst_err",   {31'd0, err},    32'd0);
    rst_n = 1'b1;
    tick(3);

    // 1: code 5, ack held high
    nY = 3'b010; nGS = 1'b0; ack = 1'b1;
    tick(6);
    chk("t1_e6",    {24'd0, nOUT},   32'hFF);
    tick(1);
    chk("t1_nOUT",  {24'd0, nOUT},   32'hDF);
    chk("t1_valid", {31'd0, valid},  32'd1);
    chk("t1_code",  {29'd0, code_o}, 32'd5);
    tick(1);
    chk("t1_vlow",  {31'd0, valid},  32'd0);
    chk("t1_hold",  {24'd0, nOUT},   32'hDF);
    tick(6);
    chk("t1_e14",   {24'd0, nOUT},   32'hDF);
    tick(1);
    chk("t1_e15",   {24'd0, nOUT},   32'hFF);
    tick(5);
    chk("t1_rel",   {24'd0, nOUT},   32'hFF);
    nGS = 1'b1;
    tick(6);

    // 2: bounce 5 -> 6 during settle
    nY = 3'b010; nGS = 1'b0;
    tick(3);
    nY = 3'b001;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("t2_wait", {24'd0, nOUT}, 32'hFF);
    end
    tick(1);
    chk("t2_nOUT", {24'd0, nOUT},   32'hBF);
    chk("t2_code", {29'd0, code_o}, 32'd6);
    nGS = 1'b1;
    tick(14);

    // 3: ack withheld for 20 cycles
    ack = 1'b0; nY = 3'b101; nGS = 1'b0;
    tick(7);
    chk("t3_valid", {31'd0, valid}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t3_vhold", {31'd0, valid}, 32'd1);
      chk("t3_ohold", {24'd0, nOUT},  32'hFB);
    end
    ack = 1'b1;
    tick(1);
    chk("t3_vfall", {31'd0, valid}, 32'd0);
    chk("t3_ofall", {24'd0, nOUT},  32'hFF);
    ack = 1'b0; nGS = 1'b1;
    tick(6);

    // 4: illegal GS+EO, then a legal code
    nGS = 1'b0; nEO = 1'b0;
    tick(3);
    nGS = 1'b1; nEO = 1'b1;
    tick(6);
    chk("t4_err",  {31'd0, err},   32'd1);
    chk("t4_nOUT", {24'd0, nOUT},  32'hFF);
    nY = 3'b100; nGS = 1'b0; ack = 1'b1;
    tick(7);
    chk("t4_dec",  {24'd0, nOUT},  32'hF7);
    chk("t4_errk", {31'd0, err},   32'd1);
    nGS = 1'b1;
    tick(12);

    // 5: nE and async reset while driving
    ack = 1'b0; nY = 3'b110; nGS = 1'b0;
    tick(9);
    chk("t5_drv",   {24'd0, nOUT},  32'hFD);
    nE = 1'b1;
    tick(1);
    chk("t5_neO",   {24'd0, nOUT},  32'hFF);
    chk("t5_neV",   {31'd0, valid}, 32'd0);
    nE = 1'b0;
    tick(6);
    chk("t5_redrv", {31'd0, valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rO",  {24'd0, nOUT},   32'hFF);
    chk("t5_rV",  {31'd0, valid},  32'd0);
    chk("t5_rC",  {29'd0, code_o}, 32'd0);
    chk("t5_rE",  {31'd0, err},    32'd0);
    tick(1);
    rst_n = 1'b1; nGS = 1'b1; ack = 1'b1;
    tick(6);

    // 6: sweep all codes
    for (int i = 0; i < 8; i++) begin
      c = 3'(i);
      e = ~(8'd1 << i);
      nY = ~c; nGS = 1'b0;
      tick(7);
      chk("t6_nOUT", {24'd0, nOUT}, {24'd0, e});
      chk("t6_one",  $countones(~nOUT), 32'd1);
      chk("t6_code", {29'd0, code_o}, {29'd0, c});
      nGS = 1'b1;
      tick(10);
    end

    tick(2);
    $display("[TB] %0d tests run, %0d failed",
             nRun, nFail);
    $finish;
  end

endmodule
